// File: rtl/stall_pipeline_pkg.sv
// Shared defaults for the stall_pipeline delay line and its stage register.
package stall_pipeline_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/stall_pipeline_stage.sv
// One XLEN-wide pipeline register with synchronous active-low clear and load enable.
module pipe_stage
  import stall_pipeline_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clock_i,
  input  logic            resetn_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  // Clear is deliberately outside the enable so reset beats stall.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/stall_pipeline.sv
// Fixed-latency DEPTH-stage delay line with a global stall that freezes every stage.
module stall_pipeline
  import stall_pipeline_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            stall,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out
);

  generate
    if (XLEN < 1) begin : g_bad_xlen
      $error("stall_pipeline: XLEN must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("stall_pipeline: DEPTH must be >= 1");
    end
  endgenerate

  logic [XLEN-1:0] stage_q [DEPTH];
  logic            shift_en;

  assign shift_en = ~stall;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [XLEN-1:0] stage_d;

      if (gi == 0) begin : g_head
        assign stage_d = data_in;
      end else begin : g_body
        assign stage_d = stage_q[gi-1];
      end

      pipe_stage #(
        .XLEN(XLEN)
      ) u_stage (
        .clock_i  (clock),
        .resetn_i (resetn),
        .en_i     (shift_en),
        .d_i      (stage_d),
        .q_o      (stage_q[gi])
      );
    end
  endgenerate

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_stall_pipeline.sv
// Scoreboard bench for stall_pipeline: a queue mirrors the words in flight, oldest first.
module tb_stall_pipeline;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clock;
  logic            resetn;
  logic            stall;
  logic [XLEN-1:0] data_in;
  logic [XLEN-1:0] data_out;

  logic [XLEN-1:0] exp_q [$];
  int              checks_total;
  int              checks_passed;
  int              tick_cnt;

  stall_pipeline #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .stall    (stall),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, got, exp, tick_cnt);
    end
  endtask

  // Drive one edge, advance the expected contents, then compare the output.
  task automatic tick(input logic [XLEN-1:0] din, input logic st, input logic rn);
    logic [XLEN-1:0] expect_out;
    data_in = din;
    stall   = st;
    resetn  = rn;
    @(posedge clock);
    #1;
    tick_cnt++;
    if (!rn) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
    end else if (!st) begin
      void'(exp_q.pop_front());
      exp_q.push_back(din);
    end
    expect_out = exp_q[0];
    $display("tick %0d rstn=%b stall=%b din=%h dout=%h exp=%h",
             tick_cnt, rn, st, din, data_out, expect_out);
    check("scoreboard", data_out, expect_out);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    tick_cnt      = 0;
    resetn  = 1'b0;
    stall   = 1'b0;
    data_in = '0;

    // Reset with all-ones input, then idle zeros.
    tick(32'hFFFF_FFFF, 1'b0, 1'b0);
    check("reset_out", data_out, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      tick(32'h0, 1'b0, 1'b1);
      check("post_reset_zero", data_out, 32'h0);
    end

    // Random streaming.
    for (int i = 0; i < 100; i++) begin
      tick($urandom, 1'b0, 1'b1);
    end

    // Fixed sequence 1..6: outputs after edges 4..6 are 1,2,3.
    for (int i = 1; i <= 6; i++) begin
      tick(i, 1'b0, 1'b1);
      if (i >= DEPTH) check("fixed_seq", data_out, i - DEPTH + 1);
    end

    // Load 10..13, stall with random input, resume with 99.
    for (int i = 10; i <= 13; i++) tick(i, 1'b0, 1'b1);
    check("stall_loaded", data_out, 32'd10);
    for (int i = 0; i < 10; i++) begin
      tick($urandom, 1'b1, 1'b1);
      check("stall_hold", data_out, 32'd10);
    end
    tick(32'd99, 1'b0, 1'b1);
    check("resume_0", data_out, 32'd11);
    tick(32'd0, 1'b0, 1'b1);
    check("resume_1", data_out, 32'd12);
    tick(32'd0, 1'b0, 1'b1);
    check("resume_2", data_out, 32'd13);
    tick(32'd0, 1'b0, 1'b1);
    check("resume_3", data_out, 32'd99);

    // Reset mid-stream, then 10 new words and drain.
    for (int i = 0; i < 5; i++) tick($urandom, 1'b0, 1'b1);
    tick($urandom, 1'b0, 1'b0);
    check("midreset", data_out, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick(32'h200 + i, 1'b0, 1'b1);
      if (i < DEPTH - 1) check("midreset_bubble", data_out, 32'h0);
      else check("midreset_data", data_out, 32'h200 + i - (DEPTH - 1));
    end
    for (int i = 0; i < DEPTH - 1; i++) tick(32'h0, 1'b0, 1'b1);

    // Reset together with stall clears every stage.
    for (int i = 0; i < 6; i++) tick($urandom | 32'h1, 1'b0, 1'b1);
    tick(32'hDEAD_BEEF, 1'b1, 1'b0);
    check("reset_stall", data_out, 32'h0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick(32'h0, 1'b0, 1'b1);
      check("reset_stall_cleared", data_out, 32'h0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
